// File: rtl/ntlm_pkg.sv
// Shared command codes, FSM states and limits for the NTLM cracker host receive path.
package ntlm_pkg;

    localparam logic [7:0] CMD_LOAD  = 8'h48;
    localparam logic [7:0] CMD_PROG  = 8'h50;
    localparam logic [7:0] CMD_START = 8'h53;

    localparam int MAX_HASHES = 64;

    typedef enum logic [2:0] {
        IDLE,
        GET_COUNT,
        GET_BYTE,
        WRITE,
        DONE,
        ERROR
    } state_e;

endpackage

// File: rtl/hash_loader_assembler.sv
// Byte shift register building one hash MSB-first; full flags a complete word.
// Latency: word and full update the cycle after shift_i; no backpressure, caller gates shift_i.
module hash_assembler #(
    parameter int HASH_BITS = 128
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 clr_i,
    input  logic                 shift_i,
    input  logic [7:0]           byte_i,
    output logic [HASH_BITS-1:0] word_o,
    output logic [3:0]           cnt_o,
    output logic                 full_o
);

    logic [HASH_BITS-1:0] word_q, word_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 full_q, full_d;

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        full_d = full_q;
        if (clr_i) begin
            cnt_d  = 4'd0;
            full_d = 1'b0;
        end else if (shift_i) begin
            word_d = {word_q[HASH_BITS-9:0], byte_i};
            // The 16th byte wraps the counter back to 0, ready for the next hash.
            cnt_d  = cnt_q + 4'd1;
            full_d = (cnt_q == 4'hF);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            word_q <= '0;
            cnt_q  <= 4'd0;
            full_q <= 1'b0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
        end
    end

    assign word_o = word_q;
    assign cnt_o  = cnt_q;
    assign full_o = full_q;

endmodule

// File: rtl/hash_loader.sv
// Host command receiver: decodes H/P/S, assembles 16-byte hashes and writes them to SRAM.
// Latency: pulses and write strobe at T+1 after the consumed byte; data_ready held until data_read.
module hash_loader
    import ntlm_pkg::*;
#(
    parameter int HASH_BITS = 128,
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic [7:0]           rx_data,
    input  logic                 data_ready,
    input  logic                 overrun_error,
    input  logic                 framing_error,
    output logic                 data_read,
    output logic                 write_enable,
    output logic [ADDR_BITS-1:0] address,
    output logic [HASH_BITS-1:0] write_data,
    output logic [6:0]           hash_count,
    output logic                 load_done,
    output logic                 load_error,
    output logic                 start_bit,
    output logic                 progress_request_byte_detected
);

    state_e     state_q, state_d;
    logic [6:0] index_q, index_d;
    logic [6:0] count_q, count_d;
    logic [6:0] hcnt_q, hcnt_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       start_q, start_d;
    logic       prog_q, prog_d;
    logic       rd_prev_q;

    logic       can_take, uart_err, take, shift, clr;
    logic [3:0] byte_cnt;
    logic       full;

    assign can_take = data_ready && !rd_prev_q;
    assign uart_err = framing_error || overrun_error;

    hash_assembler #(.HASH_BITS(HASH_BITS)) u_asm (
        .clk     (clk),
        .n_rst   (n_rst),
        .clr_i   (clr),
        .shift_i (shift),
        .byte_i  (rx_data),
        .word_o  (write_data),
        .cnt_o   (byte_cnt),
        .full_o  (full)
    );

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        count_d = count_q;
        hcnt_d  = hcnt_q;
        done_d  = done_q;
        err_d   = err_q;
        start_d = 1'b0;
        prog_d  = 1'b0;
        take    = 1'b0;
        shift   = 1'b0;
        clr     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (can_take) begin
                    take = 1'b1;
                    if (rx_data == CMD_LOAD) begin
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                        hcnt_d  = 7'd0;
                        state_d = GET_COUNT;
                    end else if (rx_data == CMD_PROG) begin
                        prog_d = 1'b1;
                    end else if (rx_data == CMD_START) begin
                        start_d = done_q;
                    end
                end
            end
            GET_COUNT: begin
                // A UART error takes priority and leaves the pending byte unconsumed.
                if (uart_err) begin
                    state_d = ERROR;
                end else if (can_take) begin
                    take = 1'b1;
                    if (rx_data == 8'd0 || rx_data > 8'(MAX_HASHES)) begin
                        state_d = ERROR;
                    end else begin
                        count_d = rx_data[6:0];
                        index_d = 7'd0;
                        clr     = 1'b1;
                        state_d = GET_BYTE;
                    end
                end
            end
            GET_BYTE: begin
                if (uart_err) begin
                    state_d = ERROR;
                end else if (can_take) begin
                    take  = 1'b1;
                    shift = 1'b1;
                    if (byte_cnt == 4'hF) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                index_d = index_q + 7'd1;
                hcnt_d  = index_q + 7'd1;
                if (index_d == count_q) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = GET_BYTE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            ERROR: begin
                err_d   = 1'b1;
                done_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            index_q   <= 7'd0;
            count_q   <= 7'd0;
            hcnt_q    <= 7'd0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            start_q   <= 1'b0;
            prog_q    <= 1'b0;
            rd_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            count_q   <= count_d;
            hcnt_q    <= hcnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            start_q   <= start_d;
            prog_q    <= prog_d;
            rd_prev_q <= take;
        end
    end

    assign data_read                      = take;
    assign write_enable                   = (state_q == WRITE) && full;
    assign address                        = {{(ADDR_BITS-7){1'b0}}, index_q};
    assign hash_count                     = hcnt_q;
    assign load_done                      = done_q;
    assign load_error                     = err_q;
    assign start_bit                      = start_q;
    assign progress_request_byte_detected = prog_q;

endmodule

// File: tb/tb_hash_loader.sv
// Self-checking bench for hash_loader: directed scenarios plus a randomized command stream
// compared against a byte-stream reference model.
module tb_hash_loader;

    localparam logic [7:0] B_LOAD  = 8'h48;
    localparam logic [7:0] B_PROG  = 8'h50;
    localparam logic [7:0] B_START = 8'h53;
    localparam int         MAXH    = 64;

    logic         clk = 1'b0;
    logic         n_rst;
    logic [7:0]   rx_data;
    logic         data_ready;
    logic         overrun_error;
    logic         framing_error;
    logic         data_read;
    logic         write_enable;
    logic [9:0]   address;
    logic [127:0] write_data;
    logic [6:0]   hash_count;
    logic         load_done;
    logic         load_error;
    logic         start_bit;
    logic         progress_request_byte_detected;

    hash_loader dut (
        .clk                            (clk),
        .n_rst                          (n_rst),
        .rx_data                        (rx_data),
        .data_ready                     (data_ready),
        .overrun_error                  (overrun_error),
        .framing_error                  (framing_error),
        .data_read                      (data_read),
        .write_enable                   (write_enable),
        .address                        (address),
        .write_data                     (write_data),
        .hash_count                     (hash_count),
        .load_done                      (load_done),
        .load_error                     (load_error),
        .start_bit                      (start_bit),
        .progress_request_byte_detected (progress_request_byte_detected)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- observation ----------------
    logic [9:0]   obs_addr[$];
    logic [127:0] obs_data[$];
    int           obs_start = 0;
    int           obs_prog  = 0;
    int           viol_we   = 0;
    int           viol_rd   = 0;
    logic         prev_we   = 1'b0;
    logic         prev_rd   = 1'b0;

    always @(negedge clk) begin
        if (n_rst) begin
            if (write_enable) begin
                obs_addr.push_back(address);
                obs_data.push_back(write_data);
            end
            if (start_bit) obs_start++;
            if (progress_request_byte_detected) obs_prog++;
            if (write_enable && prev_we) viol_we++;
            if (data_read && prev_rd) viol_rd++;
            prev_we = write_enable;
            prev_rd = data_read;
        end else begin
            prev_we = 1'b0;
            prev_rd = 1'b0;
        end
    end

    // ---------------- reference model ----------------
    int           m_mode = 0;   // 0: command, 1: expecting count, 2: collecting hash bytes
    int           m_n    = 0;
    int           m_idx  = 0;
    int           m_cnt  = 0;
    bit           m_done = 1'b0;
    bit           m_err  = 1'b0;
    logic [7:0]   m_buf[$];
    logic [9:0]   exp_addr[$];
    logic [127:0] exp_data[$];
    int           exp_start = 0;
    int           exp_prog  = 0;
    int           wr_ptr    = 0;

    task automatic model_byte(input logic [7:0] b);
        logic [127:0] w;
        case (m_mode)
            0: begin
                if (b == B_LOAD) begin
                    m_done = 1'b0; m_err = 1'b0; m_cnt = 0; m_mode = 1;
                end else if (b == B_PROG) begin
                    exp_prog++;
                end else if (b == B_START && m_done) begin
                    exp_start++;
                end
            end
            1: begin
                if (b == 8'd0 || int'(b) > MAXH) begin
                    m_err = 1'b1; m_done = 1'b0; m_mode = 0;
                end else begin
                    m_n = int'(b); m_idx = 0; m_buf.delete(); m_mode = 2;
                end
            end
            default: begin
                m_buf.push_back(b);
                if (m_buf.size() == 16) begin
                    w = '0;
                    for (int i = 0; i < 16; i++) w = (w << 8) | 128'(m_buf[i]);
                    exp_addr.push_back(10'(m_idx));
                    exp_data.push_back(w);
                    m_idx++;
                    m_cnt = m_idx;
                    m_buf.delete();
                    if (m_idx == m_n) begin
                        m_done = 1'b1; m_mode = 0;
                    end
                end
            end
        endcase
    endtask

    task automatic model_uart_err();
        if (m_mode != 0) begin
            m_err = 1'b1; m_done = 1'b0; m_mode = 0;
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_done = 1'b0; m_err = 1'b0; m_buf.delete();
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b);
        bit got = 1'b0;
        @(posedge clk); #1;
        rx_data    = b;
        data_ready = 1'b1;
        for (int n = 0; n < 64 && !got; n++) begin
            @(negedge clk);
            if (data_read) got = 1'b1;
        end
        @(posedge clk); #1;
        data_ready = 1'b0;
        if (!got) chk("consume_timeout", 128'(got), 128'(1));
        else model_byte(b);
    endtask

    task automatic send_load(input int n, input int nbytes);
        send_byte(B_LOAD);
        send_byte(8'(n));
        for (int i = 0; i < nbytes; i++) send_byte(8'($urandom));
    endtask

    task automatic pulse_err(input bit fe);
        @(posedge clk); #1;
        framing_error = fe;
        overrun_error = !fe;
        @(posedge clk); #1;
        framing_error = 1'b0;
        overrun_error = 1'b0;
        model_uart_err();
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_nwr"}, 128'(obs_addr.size()), 128'(exp_addr.size()));
        for (int i = wr_ptr; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            chk({tag, "_addr"}, 128'(obs_addr[i]), 128'(exp_addr[i]));
            chk({tag, "_data"}, obs_data[i], exp_data[i]);
        end
        wr_ptr = exp_addr.size();
    endtask

    task automatic check_state(input string tag);
        repeat (3) @(negedge clk);
        chk({tag, "_done"},  128'(load_done),  128'(m_done));
        chk({tag, "_err"},   128'(load_error), 128'(m_err));
        chk({tag, "_count"}, 128'(hash_count), 128'(m_cnt));
        chk({tag, "_start"}, 128'(obs_start),  128'(exp_start));
        chk({tag, "_prog"},  128'(obs_prog),   128'(exp_prog));
        check_writes(tag);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_dread"}, 128'(data_read),    128'(0));
        chk({tag, "_we"},    128'(write_enable), 128'(0));
        chk({tag, "_addr"},  128'(address),      128'(0));
        chk({tag, "_wdata"}, write_data,         128'(0));
        chk({tag, "_count"}, 128'(hash_count),   128'(0));
        chk({tag, "_done"},  128'(load_done),    128'(0));
        chk({tag, "_err"},   128'(load_error),   128'(0));
        chk({tag, "_start"}, 128'(start_bit),    128'(0));
        chk({tag, "_prog"},  128'(progress_request_byte_detected), 128'(0));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [127:0] seq_word;
        int           n;
        seq_word      = 128'h000102030405060708090a0b0c0d0e0f;
        n_rst         = 1'b0;
        rx_data       = 8'h00;
        data_ready    = 1'b0;
        framing_error = 1'b0;
        overrun_error = 1'b0;
        #12;
        check_zero("reset");
        @(posedge clk); #1;
        n_rst = 1'b1;

        // 'S' without a completed load is ignored; back-to-back 'P' each pulse once
        send_byte(B_START);
        @(negedge clk);
        chk("early_start", 128'(start_bit), 128'(0));
        send_byte(B_PROG);
        @(negedge clk);
        chk("prog_lat", 128'(progress_request_byte_detected), 128'(1));
        send_byte(B_PROG);
        check_state("sp");

        // single hash with a known pattern, checking exact write and done latency
        send_byte(B_LOAD);
        send_byte(8'h01);
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        @(negedge clk);
        chk("t1_we",    128'(write_enable), 128'(1));
        chk("t1_addr",  128'(address),      128'(0));
        chk("t1_data",  write_data,         seq_word);
        chk("t1_done1", 128'(load_done),    128'(0));
        @(negedge clk);
        chk("t1_done2", 128'(load_done),    128'(1));
        check_state("one");

        // two hashes then start
        send_load(2, 32);
        send_byte(B_START);
        @(negedge clk);
        chk("start_lat", 128'(start_bit), 128'(1));
        @(negedge clk);
        chk("start_one", 128'(start_bit), 128'(0));
        check_state("two");

        // bad counts
        send_load(0, 0);
        check_state("cnt0");
        send_load(65, 0);
        check_state("cnt65");

        // largest accepted count
        send_load(MAXH, 16 * MAXH);
        send_byte(B_START);
        check_state("max");

        // framing error mid second hash, then 'H' clears the error
        send_load(2, 20);
        pulse_err(1'b1);
        check_state("ferr");
        send_byte(B_LOAD);
        repeat (2) @(negedge clk);
        chk("h_clears_err", 128'(load_error), 128'(m_err));
        send_byte(8'h01);
        for (int i = 0; i < 16; i++) send_byte(8'($urandom));
        check_state("reload");

        // byte and overrun in the same cycle: error wins, byte left pending
        send_load(1, 5);
        @(posedge clk); #1;
        rx_data       = 8'hAA;
        data_ready    = 1'b1;
        overrun_error = 1'b1;
        @(negedge clk);
        chk("errwins_rd", 128'(data_read), 128'(0));
        @(posedge clk); #1;
        overrun_error = 1'b0;
        data_ready    = 1'b0;
        model_uart_err();
        check_state("errwins");

        // reset in the middle of a hash
        send_load(1, 8);
        @(posedge clk); #1;
        n_rst = 1'b0;
        #2;
        check_zero("midrst");
        @(posedge clk); #1;
        n_rst = 1'b1;
        model_reset();
        send_byte(B_LOAD);
        send_byte(8'h01);
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        check_state("postrst");

        // randomized command stream
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 5))
                0: send_byte(8'($urandom));
                1: send_byte(B_PROG);
                2: send_byte(B_START);
                3, 4: begin
                    n = int'($urandom_range(1, 3));
                    if ($urandom_range(0, 3) == 0) begin
                        send_load(n, int'($urandom_range(0, 16 * n - 1)));
                        pulse_err(1'($urandom_range(0, 1)));
                    end else begin
                        send_load(n, 16 * n);
                    end
                end
                default: send_load(int'($urandom_range(0, 80)), int'($urandom_range(0, 20)));
            endcase
        end
        check_state("rand");

        chk("we_b2b", 128'(viol_we), 128'(0));
        chk("rd_b2b", 128'(viol_rd), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hash_loader.md
# hash_loader

Host-side command receiver for the NTLM cracker. It consumes bytes from `rcv_block` (UART receive), decodes host commands, and assembles 16-byte NTLM hashes into 128-bit words written to the on-chip SRAM. It also raises the `start_bit` and `progress_request_byte_detected` pulses consumed by `controller`. It is the receive-direction counterpart of the `controller` → `tx_data` result path.

## Interface
- `HASH_BITS`, 128, width of one hash / SRAM word
- `ADDR_BITS`, 10, SRAM address width
- `MAX_HASHES`, 64, largest accepted hash count

- `clk`  in  1  system clock; one clock domain only
- `n_rst`  in  1  asynchronous, active-low reset
- `rx_data`  in  8  received byte from `rcv_block`
- `data_ready`  in  1  level; byte valid until acknowledged
- `overrun_error`  in  1  UART overrun
- `framing_error`  in  1  UART framing error
- `data_read`  out  1  one-cycle byte acknowledge to `rcv_block`
- `write_enable`  out  1  one-cycle SRAM write strobe
- `address`  out  ADDR_BITS  SRAM word address, equal to the hash index
- `write_data`  out  HASH_BITS  assembled hash
- `hash_count`  out  7  number of hashes loaded
- `load_done`  out  1  level; load complete
- `load_error`  out  1  sticky error flag
- `start_bit`  out  1  one-cycle pulse; start cracking
- `progress_request_byte_detected`  out  1  one-cycle pulse

## Operation
- **Byte consume rule:** a byte is taken in a cycle where `data_ready`=1 and `data_read` was 0 in the previous cycle. `data_read` pulses in that same cycle.
- **Commands, decoded in IDLE:**
  - 0x48 'H': load. Clears `load_done`, `load_error` and `hash_count`, then goes to GET_COUNT.
  - 0x50 'P': progress request. Pulses `progress_request_byte_detected`.
  - 0x53 'S': start. Pulses `start_bit` only if `load_done`=1; otherwise ignored.
  - Any other byte is consumed and dropped.
- **GET_COUNT:** the byte N is the hash count.
  - N=0 or N>MAX_HASHES → ERROR.
  - Otherwise go to GET_BYTE, with byte counter = 0 and index = 0.
- **GET_BYTE:** bytes are data, including 0x48, 0x50 and 0x53.
  - Bytes shift in MSB-first; the first byte lands in `write_data[127:120]`.
  - On the 16th byte → WRITE.
- **WRITE:** one cycle.
  - `write_enable`=1, `address`=index, `write_data`=assembled word.
  - index increments; `hash_count`=index+1.
  - If index+1==N → DONE, else → GET_BYTE.
- **DONE:** sets `load_done`=1, then returns to IDLE.
- **ERROR:** sets `load_error`=1 and `load_done`=0, then returns to IDLE.
  - Hashes already written stay in SRAM.
  - `hash_count` holds the number completed.
- **UART errors:** `framing_error` or `overrun_error` high in GET_COUNT or GET_BYTE → ERROR next cycle; the offending byte is not consumed. In IDLE these errors are ignored.
- **Widths:**
  - The byte counter is 4 bits and wraps from 15 to 0 on WRITE.
  - index is 7 bits and is zero-extended onto `address`.

## Timing
- **Reset values:** all outputs 0; state IDLE.
- **Reset mid-load:** aborts immediately; nothing is written afterwards.
- **Latencies, with the byte consumed at cycle T:**
  - `start_bit` or progress pulse at T+1.
  - After the 16th byte: `write_enable` at T+1.
  - After the last hash: `load_done` at T+2.
- `write_enable` is never asserted in two consecutive cycles. A new byte arriving during WRITE is not consumed until the cycle after WRITE.
- `data_read` is never high for two consecutive cycles.
- **Back-to-back 'P' bytes:** each produces exactly one pulse.
- **Simultaneous byte and error in a load state:** the error wins.

## Structure
- Package `ntlm_pkg` holds:
  - command constants `CMD_LOAD`=8'h48, `CMD_PROG`=8'h50, `CMD_START`=8'h53;
  - the state enum (IDLE, GET_COUNT, GET_BYTE, WRITE, DONE, ERROR);
  - `MAX_HASHES`.
- One sub-module, `hash_assembler`: a 128-bit byte shift register with a 4-bit byte counter and a `full` flag.
- The FSM, index and counters live in `hash_loader`.

## Test plan
- Send 'H', 0x01, bytes 0x00..0x0F → one `write_enable`, `address`=0, `write_data`=128'h000102…0F; `load_done`=1 two cycles after the last byte; `hash_count`=1.
- Send 'H', 0x02, 32 bytes, then 'S' → writes to addresses 0 and 1; `start_bit` single pulse one cycle after 'S' is consumed.
- Send 'S' before any load, then 'P' → no `start_bit`; exactly one `progress_request_byte_detected` pulse.
- Send 'H', 0x00; separately send 'H', 0x41 → `load_error`=1, no writes, `load_done`=0 in both cases.
- Send 'H', 0x02, 20 bytes, then raise `framing_error` → one write at address 0, `load_error`=1, `hash_count`=1; a following 'H' clears `load_error`.
- Assert `n_rst` after 8 data bytes → all outputs 0; a subsequent full 1-hash load writes to address 0 correctly.
